// File: rtl/pwm_pkg.sv
// Shared constants, channel state encoding and duty arithmetic helpers for the
// ramped multi-channel PWM bank.
package pwm_pkg;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_BITS          = 10;
  localparam int DEF_MAX_VALUE     = 1000;
  localparam int DEF_PRESCALE      = 250;
  localparam int DEF_PRESCALE_BITS = 8;
  localparam int DEF_RAMP_STEP     = 8;

  typedef enum logic [1:0] {
    SETTLED   = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } chan_state_e;

  // Saturate a requested target at the period length instead of letting it wrap.
  function automatic int clamp_target(input int value, input int max_value);
    return (value > max_value) ? max_value : value;
  endfunction

  // One slew-limited move from duty toward target; lands exactly on target when close.
  function automatic int ramp_toward(input int duty, input int target, input int step);
    if (target > duty)
      return ((target - duty) > step) ? duty + step : target;
    else
      return ((duty - target) > step) ? duty - step : target;
  endfunction

endpackage

// File: rtl/pwm_ramp_bank_if.sv
// Host-side bundle for the PWM bank: load strobe/mask/targets in, PWM outputs,
// applied duties and settled flags out.
interface pwm_ramp_bank_if #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 10
);
  logic                     load;
  logic [CHANNELS-1:0]      load_mask;
  logic [CHANNELS*BITS-1:0] target;
  logic                     immediate;
  logic [CHANNELS-1:0]      signal;
  logic [CHANNELS*BITS-1:0] duty;
  logic [CHANNELS-1:0]      settled;

  modport master (output load, load_mask, target, immediate,
                  input  signal, duty, settled);
  modport slave  (input  load, load_mask, target, immediate,
                  output signal, duty, settled);
endinterface

// File: rtl/pwm_ramp_channel.sv
// One PWM channel: target/duty registers, slew state machine, phase comparator
// and registered output. Duty only moves on the shared period wrap.
module pwm_ramp_channel
  import pwm_pkg::*;
#(
  parameter int BITS         = DEF_BITS,
  parameter int MAX_VALUE    = DEF_MAX_VALUE,
  parameter int RAMP_STEP    = DEF_RAMP_STEP,
  parameter int PHASE_OFFSET = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wrap_tick,
  input  logic            load_en,
  input  logic            immediate,
  input  logic [BITS-1:0] target_in,
  input  logic [BITS-1:0] counter,
  output logic            signal,
  output logic [BITS-1:0] duty,
  output logic            settled
);

  logic [BITS-1:0] target, target_nx, duty_nx, phase;
  logic [BITS:0]   phase_sum;
  logic            imm_pend, imm_pend_nx;
  chan_state_e     state, state_nx;

  function automatic chan_state_e dir_of(input logic [BITS-1:0] d, input logic [BITS-1:0] t);
    if (t == d)     return SETTLED;
    else if (t > d) return RAMP_UP;
    else            return RAMP_DOWN;
  endfunction

  assign phase_sum = {1'b0, counter} + (BITS+1)'(PHASE_OFFSET);
  assign phase     = (phase_sum >= (BITS+1)'(MAX_VALUE))
                   ? BITS'(phase_sum - (BITS+1)'(MAX_VALUE))
                   : phase_sum[BITS-1:0];

  // The wrap step is evaluated against the old target; a load in the same cycle
  // lands afterwards, so a coincident load only affects the following period.
  always_comb begin
    target_nx   = target;
    duty_nx     = duty;
    imm_pend_nx = imm_pend;
    state_nx    = state;
    if (wrap_tick) begin
      duty_nx     = imm_pend ? target
                             : BITS'(ramp_toward(int'(duty), int'(target), RAMP_STEP));
      imm_pend_nx = 1'b0;
      state_nx    = dir_of(duty_nx, target);
    end
    if (load_en) begin
      target_nx   = BITS'(clamp_target(int'(target_in), MAX_VALUE));
      imm_pend_nx = immediate;
      // A direction reversal while ramping is picked up at the next wrap.
      if (target_nx == duty_nx)
        state_nx = SETTLED;
      else if (state_nx == SETTLED)
        state_nx = dir_of(duty_nx, target_nx);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target   <= '0;
      duty     <= '0;
      imm_pend <= 1'b0;
      state    <= SETTLED;
      settled  <= 1'b1;
      signal   <= 1'b0;
    end else begin
      target   <= target_nx;
      duty     <= duty_nx;
      imm_pend <= imm_pend_nx;
      state    <= state_nx;
      settled  <= (state_nx == SETTLED);
      signal   <= (phase < duty);
    end
  end

endmodule

// File: rtl/pwm_ramp_bank.sv
// Multi-channel PWM bank with shared prescaler and period counter and per-channel
// ramped duty updates. Define PWM_PHASE_STAGGER_EN to spread channel turn-on phases.
module pwm_ramp_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int BITS          = DEF_BITS,
  parameter int MAX_VALUE     = DEF_MAX_VALUE,
  parameter int PRESCALE      = DEF_PRESCALE,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int RAMP_STEP     = DEF_RAMP_STEP
) (
  input  logic            clock,
  input  logic            reset,
  pwm_ramp_bank_if.slave  bus
);

  logic [PRESCALE_BITS-1:0] prescale_count;
  logic [BITS-1:0]          counter;
  logic                     tick, wrap_tick;

  assign tick      = (prescale_count == PRESCALE_BITS'(PRESCALE - 1));
  assign wrap_tick = tick && (counter == BITS'(MAX_VALUE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_count <= '0;
      counter        <= '0;
    end else begin
      prescale_count <= tick ? '0 : prescale_count + 1'b1;
      if (tick)
        counter <= wrap_tick ? '0 : counter + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFFSET = (i * (MAX_VALUE / CHANNELS)) % MAX_VALUE;
`else
    localparam int OFFSET = 0;
`endif
    pwm_ramp_channel #(
      .BITS         (BITS),
      .MAX_VALUE    (MAX_VALUE),
      .RAMP_STEP    (RAMP_STEP),
      .PHASE_OFFSET (OFFSET)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .wrap_tick (wrap_tick),
      .load_en   (bus.load && bus.load_mask[i]),
      .immediate (bus.immediate),
      .target_in (bus.target[i*BITS +: BITS]),
      .counter   (counter),
      .signal    (bus.signal[i]),
      .duty      (bus.duty[i*BITS +: BITS]),
      .settled   (bus.settled[i])
    );
  end

endmodule

// File: tb/tb_pwm_ramp_bank.sv
// Self-checking bench for pwm_ramp_bank: directed scenarios plus random loads,
// every cycle compared against a cycle-level arithmetic model of the bank.
module tb_pwm_ramp_bank;
  localparam int CH = 2, B = 4, M = 10, P = 2, S = 3;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int OFFS = M / CH;
`else
  localparam int OFFS = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   errors = 0, checks = 0;

  pwm_ramp_bank_if #(.CHANNELS(CH), .BITS(B)) bus ();

  pwm_ramp_bank #(
    .CHANNELS(CH), .BITS(B), .MAX_VALUE(M), .PRESCALE(P), .PRESCALE_BITS(1), .RAMP_STEP(S)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: tick/period bookkeeping in plain integers.
  int          m_pre = 0, m_cnt = 0;
  int          m_tgt[CH], m_duty[CH];
  bit          m_imm[CH];
  logic [CH-1:0] m_sig = '0, m_set = '1;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic bit is_tick();
    return m_pre == P - 1;
  endfunction
  function automatic bit is_wrap();
    return is_tick() && m_cnt == M - 1;
  endfunction
  function automatic bit loaded(input int i);
    return bus.load && bus.load_mask[i];
  endfunction
  function automatic int next_duty(input int i);
    if (!is_wrap()) return m_duty[i];
    if (m_imm[i]) return m_tgt[i];
    if (m_tgt[i] >= m_duty[i]) return m_duty[i] + imin(S, m_tgt[i] - m_duty[i]);
    return m_duty[i] - imin(S, m_duty[i] - m_tgt[i]);
  endfunction
  function automatic int next_tgt(input int i);
    if (loaded(i)) return imin(int'(bus.target[i*B +: B]), M);
    return m_tgt[i];
  endfunction
  function automatic bit next_imm(input int i);
    if (loaded(i)) return bus.immediate;
    if (is_wrap()) return 1'b0;
    return m_imm[i];
  endfunction
  function automatic logic [CH*B-1:0] exp_duty();
    logic [CH*B-1:0] v;
    for (int i = 0; i < CH; i++) v[i*B +: B] = B'(m_duty[i]);
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pre <= 0;
      m_cnt <= 0;
      m_sig <= '0;
      m_set <= '1;
      for (int i = 0; i < CH; i++) begin
        m_tgt[i] <= 0; m_duty[i] <= 0; m_imm[i] <= 1'b0;
      end
    end else begin
      m_pre <= is_tick() ? 0 : m_pre + 1;
      if (is_tick()) m_cnt <= (m_cnt + 1) % M;
      for (int i = 0; i < CH; i++) begin
        m_sig[i]  <= (((m_cnt + i * OFFS) % M) < m_duty[i]);
        m_duty[i] <= next_duty(i);
        m_tgt[i]  <= next_tgt(i);
        m_imm[i]  <= next_imm(i);
        m_set[i]  <= (next_duty(i) == next_tgt(i));
      end
    end
  end

  task automatic apply_reset();
    bus.load = 1'b0; bus.load_mask = '0; bus.target = '0; bus.immediate = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic do_load(input logic [CH-1:0] mask, input int t0, input int t1, input bit imm);
    bus.load = 1'b1; bus.load_mask = mask; bus.target = {B'(t1), B'(t0)}; bus.immediate = imm;
    @(negedge clock);
    bus.load = 1'b0; bus.immediate = 1'b0;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.load_mask = '0; bus.target = '0; bus.immediate = 1'b0;
    reset = 1'b0; #1 reset = 1'b1; #1;
    checks++;
    if (bus.signal !== 2'b00 || bus.duty !== 8'h00 || bus.settled !== 2'b11) begin
      errors++;
      $display("FAIL reset_state got sig=%b duty=%h set=%b want sig=00 duty=00 set=11",
               bus.signal, bus.duty, bus.settled);
    end
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      checks++;
      if (bus.signal !== 2'b00 || {bus.duty, bus.settled} !== {exp_duty(), m_set}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got sig=%b duty=%h set=%b want sig=00 duty=%h set=%b",
                 k, bus.signal, bus.duty, bus.settled, exp_duty(), m_set);
      end
    end
  endtask

  task automatic test_immediate();
    int n = 0, hi0 = 0, hi1 = 0;
    apply_reset();
    do_load(2'b01, 5, 0, 1'b1);
    while (bus.duty[B-1:0] !== 4'd5 && n < 60) begin
      @(negedge clock); n++;
      checks++;
      if ({bus.signal, bus.duty, bus.settled} !== {m_sig, exp_duty(), m_set}) begin
        errors++;
        $display("FAIL model_immediate got %b/%h/%b want %b/%h/%b",
                 bus.signal, bus.duty, bus.settled, m_sig, exp_duty(), m_set);
      end
    end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL immediate_wait got duty=%h want duty0=5", bus.duty); end
    @(negedge clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      hi0 += int'(bus.signal[0]);
      hi1 += int'(bus.signal[1]);
    end
    checks++;
    if (hi0 != 20) begin errors++; $display("FAIL immediate_high0 got %0d high clocks want 20", hi0); end
    checks++;
    if (hi1 != 0) begin errors++; $display("FAIL immediate_low1 got %0d high clocks want 0", hi1); end
  endtask

  task automatic test_ramp_up();
    int q[$];
    int exp_seq[4] = '{3, 6, 9, 10};
    int prev = 0, n = 0, hi = 0;
    apply_reset();
    do_load(2'b01, 10, 0, 1'b0);
    while (q.size() < 4 && n < 120) begin
      @(negedge clock); n++;
      checks++;
      if ({bus.signal, bus.duty, bus.settled} !== {m_sig, exp_duty(), m_set}) begin
        errors++;
        $display("FAIL model_ramp_up got %b/%h/%b want %b/%h/%b",
                 bus.signal, bus.duty, bus.settled, m_sig, exp_duty(), m_set);
      end
      if (int'(bus.duty[B-1:0]) != prev) begin
        prev = int'(bus.duty[B-1:0]);
        q.push_back(prev);
        checks++;
        if (bus.settled[0] !== (prev == 10)) begin
          errors++;
          $display("FAIL ramp_settled duty=%0d got settled=%b want %b", prev, bus.settled[0], prev == 10);
        end
      end
    end
    checks++;
    if (q.size() < 4) begin errors++; $display("FAIL ramp_up_wait got %0d steps want 4", q.size()); end
    for (int k = 0; k < q.size() && k < 4; k++) begin
      checks++;
      if (q[k] != exp_seq[k]) begin
        errors++; $display("FAIL ramp_up_step%0d got %0d want %0d", k, q[k], exp_seq[k]);
      end
    end
    @(negedge clock);
    for (int k = 0; k < 40; k++) begin @(negedge clock); hi += int'(bus.signal[0]); end
    checks++;
    if (hi != 40) begin errors++; $display("FAIL full_duty_high got %0d of 40 want 40", hi); end
  endtask

  task automatic test_clamp();
    int mx = 0;
    apply_reset();
    do_load(2'b10, 7, 15, 1'b0);
    for (int k = 0; k < 120; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.signal, bus.duty, bus.settled} !== {m_sig, exp_duty(), m_set}) begin
        errors++;
        $display("FAIL model_clamp got %b/%h/%b want %b/%h/%b",
                 bus.signal, bus.duty, bus.settled, m_sig, exp_duty(), m_set);
      end
      if (int'(bus.duty[2*B-1:B]) > mx) mx = int'(bus.duty[2*B-1:B]);
    end
    checks++;
    if (mx != 10) begin errors++; $display("FAIL clamp_max got duty1 max=%0d want 10", mx); end
    checks++;
    if (bus.settled !== 2'b11 || bus.duty[B-1:0] !== 4'd0) begin
      errors++; $display("FAIL clamp_final got set=%b duty=%h want set=11 duty=a0", bus.settled, bus.duty);
    end
  endtask

  task automatic test_reversal();
    int q[$];
    int prev, n = 0, mn = 15;
    apply_reset();
    do_load(2'b01, 10, 0, 1'b0);
    while (bus.duty[B-1:0] !== 4'd6 && n < 100) begin @(negedge clock); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL reversal_wait got duty=%h want duty0=6", bus.duty); end
    do_load(2'b01, 2, 0, 1'b0);
    prev = int'(bus.duty[B-1:0]);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.signal, bus.duty, bus.settled} !== {m_sig, exp_duty(), m_set}) begin
        errors++;
        $display("FAIL model_reversal got %b/%h/%b want %b/%h/%b",
                 bus.signal, bus.duty, bus.settled, m_sig, exp_duty(), m_set);
      end
      if (int'(bus.duty[B-1:0]) != prev) begin prev = int'(bus.duty[B-1:0]); q.push_back(prev); end
      if (prev < mn) mn = prev;
    end
    checks++;
    if (q.size() != 2 || q[0] != 3 || q[1] != 2) begin
      errors++; $display("FAIL reversal_steps got %p want '{3, 2}", q);
    end
    checks++;
    if (mn != 2 || bus.settled[0] !== 1'b1) begin
      errors++; $display("FAIL reversal_final got min=%0d settled=%b want min=2 settled=1", mn, bus.settled[0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.signal, bus.duty, bus.settled} !== {m_sig, exp_duty(), m_set}) begin
        errors++;
        $display("FAIL model_random cyc=%0d got %b/%h/%b want %b/%h/%b",
                 k, bus.signal, bus.duty, bus.settled, m_sig, exp_duty(), m_set);
      end
      bus.load      = ($urandom_range(7) == 0);
      bus.load_mask = 2'($urandom_range(3));
      bus.target    = 8'($urandom_range(255));
      bus.immediate = ($urandom_range(3) == 0);
    end
    bus.load = 1'b0; bus.immediate = 1'b0;
  endtask

  task automatic test_stagger_reset();
    int n = 0, r0 = -1, r1 = -1;
    logic [CH-1:0] prev;
    apply_reset();
    do_load(2'b11, 5, 5, 1'b1);
    while (bus.duty !== 8'h55 && n < 60) begin @(negedge clock); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL stagger_wait got duty=%h want 55", bus.duty); end
    prev = bus.signal;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (r0 < 0 && !prev[0] && bus.signal[0]) r0 = k;
      if (r0 >= 0 && r1 < 0 && !prev[1] && bus.signal[1]) r1 = k;
      prev = bus.signal;
    end
    checks++;
    if (r0 < 0 || r1 < 0 || (r1 - r0) != OFFS * P) begin
      errors++; $display("FAIL stagger_edges got rise0=%0d rise1=%0d want gap %0d clocks", r0, r1, OFFS * P);
    end
    n = 0;
    while (bus.signal[0] !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (bus.signal !== 2'b00 || bus.duty !== 8'h00 || bus.settled !== 2'b11) begin
      errors++;
      $display("FAIL midreset got sig=%b duty=%h set=%b want sig=00 duty=00 set=11",
               bus.signal, bus.duty, bus.settled);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_ramp_up();
    test_clamp();
    test_reversal();
    test_random();
    test_stagger_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
